branch_target_buffer: RTL and testbench



---
 rtl/branch_target_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_branch_target_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//
// Fetch-stage branch target buffer, 2-way set associative with one LRU bit
// per set. A lookup is combinational from the stored state. Entries are
// allocated or refreshed from execute-stage branch resolution.
//
// Optional feature macro: BTB_WRITE_BYPASS_EN
//   When defined, a taken update whose PC matches the lookup PC in the same
//   cycle is forwarded to the lookup outputs in that cycle.
//
// Parameters:
//   ADDR_WIDTH  PC / target width in bits
//   SETS        number of sets (power of two, >= 2)
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous reset, active-high
//   i_req_valid    fetch lookup valid
//   i_req_pc       fetch PC
//   o_hit          lookup hit (qualified by i_req_valid)
//   o_target       stored target on hit, 0 on miss
//   o_is_jump      hit entry is an unconditional jump, 0 on miss
//   i_upd_valid    execute-stage resolved branch/jump
//   i_upd_pc       PC of the resolved instruction
//   i_upd_target   resolved target
//   i_upd_is_jump  instruction is an unconditional jump
//   i_upd_taken    resolved outcome taken (1 for jumps)
//   i_flush        invalidate the whole table
// ---------------------------------------------------------------------------
module branch_target_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    output logic                  o_hit,
    output logic [ADDR_WIDTH-1:0] o_target,
    output logic                  o_is_jump,
    input  logic                  i_upd_valid,
    input  logic [ADDR_WIDTH-1:0] i_upd_pc,
    input  logic [ADDR_WIDTH-1:0] i_upd_target,
    input  logic                  i_upd_is_jump,
    input  logic                  i_upd_taken,
    input  logic                  i_flush
);

    localparam int INDEX_BITS = $clog2(SETS);
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int WAYS       = 2;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic                  valid_q  [SETS][WAYS];
    logic [TAG_BITS-1:0]   tag_q    [SETS][WAYS];
    logic [ADDR_WIDTH-1:0] target_q [SETS][WAYS];
    logic                  jump_q   [SETS][WAYS];
    // LRU bit names the victim way of the set.
    logic                  lru_q    [SETS];

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;

    assign req_idx = i_req_pc[INDEX_BITS+1:2];
    assign req_tag = i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign upd_idx = i_upd_pc[INDEX_BITS+1:2];
    assign upd_tag = i_upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];

    // Byte-offset bits carry no information for a word-aligned fetch.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_req_pc[1:0], i_upd_pc[1:0]};

    // -----------------------------------------------------------------------
    // Lookup path (combinational from stored state)
    // -----------------------------------------------------------------------
    logic req_m0;
    logic req_m1;
    logic state_hit;
    logic state_way;

    always_comb begin
        req_m0    = valid_q[req_idx][0] && (tag_q[req_idx][0] == req_tag);
        req_m1    = valid_q[req_idx][1] && (tag_q[req_idx][1] == req_tag);
        state_hit = i_req_valid && (req_m0 || req_m1);
        // Way 0 wins if both ways ever match.
        state_way = !req_m0;
    end

    logic byp_hit;
`ifdef BTB_WRITE_BYPASS_EN
    assign byp_hit = !rst && i_req_valid && i_upd_valid && i_upd_taken && !i_flush &&
                     (i_upd_pc[ADDR_WIDTH-1:2] == i_req_pc[ADDR_WIDTH-1:2]);
`else
    assign byp_hit = 1'b0;
`endif

    always_comb begin
        o_hit     = 1'b0;
        o_target  = '0;
        o_is_jump = 1'b0;
        if (byp_hit) begin
            o_hit     = 1'b1;
            o_target  = i_upd_target;
            o_is_jump = i_upd_is_jump;
        end else if (state_hit) begin
            o_hit     = 1'b1;
            o_target  = target_q[req_idx][state_way];
            o_is_jump = jump_q[req_idx][state_way];
        end
    end

    // -----------------------------------------------------------------------
    // Update path
    // -----------------------------------------------------------------------
    logic upd_m0;
    logic upd_m1;
    logic upd_hit;
    logic upd_way;
    logic upd_we;      // write tag/target/is_jump/valid into upd_way
    logic upd_touch;   // update sets this set's LRU bit

    always_comb begin
        upd_m0  = valid_q[upd_idx][0] && (tag_q[upd_idx][0] == upd_tag);
        upd_m1  = valid_q[upd_idx][1] && (tag_q[upd_idx][1] == upd_tag);
        upd_hit = upd_m0 || upd_m1;

        if (upd_hit) begin
            upd_way = !upd_m0;
        end else if (!valid_q[upd_idx][0]) begin
            upd_way = 1'b0;
        end else if (!valid_q[upd_idx][1]) begin
            upd_way = 1'b1;
        end else begin
            upd_way = lru_q[upd_idx];
        end

        upd_we    = 1'b0;
        upd_touch = 1'b0;
        if (i_upd_valid && !i_flush) begin
            if (upd_hit) begin
                // A not-taken conditional branch keeps its stored target.
                upd_we    = i_upd_taken || i_upd_is_jump;
                upd_touch = 1'b1;
            end else if (i_upd_taken) begin
                upd_we    = 1'b1;
                upd_touch = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Valid / LRU state: flush > update > lookup touch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                lru_q[s] <= 1'b0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else if (i_flush) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                lru_q[s] <= 1'b0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else begin
            // Later assignment to the same set lets the update's LRU win.
            if (state_hit) begin
                lru_q[req_idx] <= !state_way;
            end
            if (upd_touch) begin
                lru_q[upd_idx] <= !upd_way;
            end
            if (upd_we) begin
                valid_q[upd_idx][upd_way] <= 1'b1;
            end
        end
    end

    // Entry payload has no reset; valid bits gate its use.
    always_ff @(posedge clk) begin
        if (!rst && upd_we) begin
            tag_q[upd_idx][upd_way]    <= upd_tag;
            target_q[upd_idx][upd_way] <= i_upd_target;
            jump_q[upd_idx][upd_way]   <= i_upd_is_jump;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic [31:0] i_req_pc;
    logic        o_hit;
    logic [31:0] o_target;
    logic        o_is_jump;
    logic        i_upd_valid;
    logic [31:0] i_upd_pc;
    logic [31:0] i_upd_target;
    logic        i_upd_is_jump;
    logic        i_upd_taken;
    logic        i_flush;

    int total;
    int bad;

    branch_target_buffer #(.ADDR_WIDTH(32), .SETS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req_pc     (i_req_pc),
        .o_hit        (o_hit),
        .o_target     (o_target),
        .o_is_jump    (o_is_jump),
        .i_upd_valid  (i_upd_valid),
        .i_upd_pc     (i_upd_pc),
        .i_upd_target (i_upd_target),
        .i_upd_is_jump(i_upd_is_jump),
        .i_upd_taken  (i_upd_taken),
        .i_flush      (i_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lookup and check all three outputs (combinational, checked #1 after drive).
    task automatic look(input string tag, input logic [31:0] pc,
                        input logic hit, input logic [31:0] tgt, input logic jmp);
        i_req_valid = 1'b1;
        i_req_pc    = pc;
        #1;
        chk({tag, "_hit"}, {31'd0, o_hit}, {31'd0, hit});
        chk({tag, "_tgt"}, o_target, tgt);
        chk({tag, "_jmp"}, {31'd0, o_is_jump}, {31'd0, jmp});
        i_req_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic taken, input logic jmp);
        i_upd_valid   = 1'b1;
        i_upd_pc      = pc;
        i_upd_target  = tgt;
        i_upd_taken   = taken;
        i_upd_is_jump = jmp;
        tick();
        i_upd_valid   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_pc = '0;
        i_upd_valid = 1'b0; i_upd_pc = '0; i_upd_target = '0;
        i_upd_is_jump = 1'b0; i_upd_taken = 1'b0; i_flush = 1'b0;

        // Reset state
        look("rst_look", 32'h0040_0010, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        look("post_rst", 32'h0040_0010, 1'b0, 32'h0, 1'b0);

        // Basic allocate and next-cycle hit (set 4, way 0)
        upd(32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0);
        look("alloc_a", 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
        look("byteoff", 32'h0040_0013, 1'b1, 32'h0040_0100, 1'b0);
        i_req_valid = 1'b0; i_req_pc = 32'h0040_0010;
        #1;
        chk("reqv0_hit", {31'd0, o_hit}, 32'd0);
        chk("reqv0_tgt", o_target, 32'd0);

        // Second way of set 4 (jump)
        upd(32'h0041_0010, 32'h0041_0200, 1'b1, 1'b1);
        look("alloc_b", 32'h0041_0010, 1'b1, 32'h0041_0200, 1'b1);
        // Touch A so B becomes LRU victim
        look("touch_a", 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
        i_req_valid = 1'b1; i_req_pc = 32'h0040_0010;
        tick();
        i_req_valid = 1'b0;
        upd(32'h0042_0010, 32'h0042_0300, 1'b1, 1'b0);
        look("evict_b", 32'h0041_0010, 1'b0, 32'h0, 1'b0);
        look("keep_a",  32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
        look("new_c",   32'h0042_0010, 1'b1, 32'h0042_0300, 1'b0);

        // Not-taken updates
        upd(32'h0040_0020, 32'h0040_0777, 1'b0, 1'b0);
        look("nt_miss", 32'h0040_0020, 1'b0, 32'h0, 1'b0);
        upd(32'h0040_0010, 32'hDEAD_0000, 1'b0, 1'b0);
        look("nt_keep", 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);

        // Taken refresh of existing entry changes target
        upd(32'h0042_0010, 32'h0042_0400, 1'b1, 1'b1);
        look("refresh", 32'h0042_0010, 1'b1, 32'h0042_0400, 1'b1);

        // Flush concurrent with taken update
        i_flush = 1'b1;
        upd(32'h0040_0040, 32'h0040_0500, 1'b1, 1'b0);
        i_flush = 1'b0;
        look("fl_upd", 32'h0040_0040, 1'b0, 32'h0, 1'b0);
        look("fl_a",   32'h0040_0010, 1'b0, 32'h0, 1'b0);
        look("fl_c",   32'h0042_0010, 1'b0, 32'h0, 1'b0);

        // Same-cycle update and lookup
        i_upd_valid = 1'b1; i_upd_pc = 32'h0040_0030; i_upd_target = 32'h0040_0200;
        i_upd_taken = 1'b1; i_upd_is_jump = 1'b0;
`ifdef BTB_WRITE_BYPASS_EN
        look("same_cyc", 32'h0040_0030, 1'b1, 32'h0040_0200, 1'b0);
`else
        look("same_cyc", 32'h0040_0030, 1'b0, 32'h0, 1'b0);
`endif
        tick();
        i_upd_valid = 1'b0;
        look("next_cyc", 32'h0040_0030, 1'b1, 32'h0040_0200, 1'b0);

        // Asynchronous reset mid-update: outputs clear at once, update dropped
        i_upd_valid = 1'b1; i_upd_pc = 32'h0040_0050; i_upd_target = 32'h0040_0600;
        i_upd_taken = 1'b1; i_upd_is_jump = 1'b1;
        #2;
        rst = 1'b1;
        look("async_rst", 32'h0040_0030, 1'b0, 32'h0, 1'b0);
        tick();
        i_upd_valid = 1'b0;
        rst = 1'b0;
        tick();
        look("rst_drop", 32'h0040_0050, 1'b0, 32'h0, 1'b0);
        look("rst_clr",  32'h0040_0030, 1'b0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
